// File: rtl/mux8_arb_pkg.sv
// mux8_arb_pkg: shared constants and state encoding for the Mux8 bus arbiter.
package mux8_arb_pkg;
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] LAST_RST = 3'd7;
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin picker; first candidate after `last` wins.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    input  logic [N_REQ-1:0] excl,
    output logic             found,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);
    logic [N_REQ-1:0] cand;
    assign cand = req & ~excl;
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && cand[last + SEL_W'(i)]) begin
                found = 1'b1;
                idx   = last + SEL_W'(i);
            end
        end
        onehot = found ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx) : '0;
    end
endmodule

// File: rtl/mux8_arbiter.sv
// mux8_arbiter: round-robin owner of the shared Mux8 bus with registered grant/sel
module mux8_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);
  state_t           state, state_nx;
  logic [SEL_W-1:0] last, last_nx, sel_nx, pick_idx;
  logic [N_REQ-1:0] grant_nx, excl, pick_onehot;
  logic             pick_found, owned, preempt, keep, new_grant;
  rr_pick8 u_pick (
    .req    (req),
    .last   (last),
    .excl   (excl),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );
`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hold_cnt <= '0;
    else
      hold_cnt <= new_grant ? '0 : (keep && hold_cnt != HOLD_LAST) ? hold_cnt + 8'd1 : hold_cnt;
  end
  assign preempt = (hold_cnt == HOLD_LAST) && |(req & ~grant);
`else
  assign preempt = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end
  always_comb begin
    owned     = |(req & grant);
    keep      = (state == OWN) && owned && !preempt;
    excl      = (state == OWN) ? grant : '0;
    new_grant = !keep && pick_found;
    state_nx  = (keep || pick_found) ? OWN : IDLE;
  end
  always_comb begin
    grant_nx = keep ? grant : pick_onehot;
    sel_nx   = new_grant ? pick_idx : sel;
    last_nx  = new_grant ? pick_idx : last;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
      sel   <= '0;
      busy  <= 1'b0;
      last  <= LAST_RST;
    end else begin
      grant <= grant_nx;
      sel   <= sel_nx;
      busy  <= (state_nx == OWN);
      last  <= last_nx;
    end
  end
endmodule

// File: tb/tb_mux8_arbiter.sv
// tb_mux8_arbiter: directed self-checking bench for mux8_arbiter
module tb_mux8_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  int         tests = 0;
  int         fails = 0;
  always #5 clk = ~clk;
  mux8_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant),
    .sel   (sel),
    .busy  (busy)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag, input logic [7:0] g, input logic [2:0] s, input logic b);
    check({tag, ".grant"}, grant, g);
    check({tag, ".sel"}, {5'd0, sel}, {5'd0, s});
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
  endtask
  initial begin
    step();
    step();
    check_all("in_reset", 8'h00, 3'd0, 1'b0);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check_all("idle", 8'h00, 3'd0, 1'b0);
    end
    req = 8'h81;
    check("pre_latency", grant, 8'h00);
    step();
    check_all("grant0", 8'h01, 3'd0, 1'b1);
    req = 8'h80;
    step();
    check_all("switch7", 8'h80, 3'd7, 1'b1);
    req = 8'h00;
    step();
    check_all("release_idle", 8'h00, 3'd7, 1'b0);
    req = 8'hFF;
    step();
    check_all("rr_start", 8'h01, 3'd0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      req = ~(8'h01 << ((i - 1) % 8));
      step();
      check_all("rr_visit", 8'h01 << (i % 8), 3'(i % 8), 1'b1);
      req = 8'hFF;
    end
    req = 8'h00;
    step();
    check_all("rr_idle", 8'h00, 3'd0, 1'b0);
    req = 8'h08;
    step();
    check_all("own3", 8'h08, 3'd3, 1'b1);
    step();
    check_all("own3_hold", 8'h08, 3'd3, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 3'd0, 1'b0);
    #2 rst_n = 1'b1;
    check("post_rst_wait", grant, 8'h00);
    step();
    check_all("regrant3", 8'h08, 3'd3, 1'b1);
    req = 8'h00;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req = 8'h24;
    for (int c = 0; c < 12; c++) begin
      step();
`ifdef ARB_HOLD_LIMIT_EN
      check_all("hold_pair", ((c / 4) % 2 == 1) ? 8'h20 : 8'h04, ((c / 4) % 2 == 1) ? 3'd5 : 3'd2, 1'b1);
`else
      check_all("hold_pair", 8'h04, 3'd2, 1'b1);
`endif
    end
    req = 8'h04;
    for (int c = 0; c < 8; c++) begin
      step();
      check_all("hold_alone", 8'h04, 3'd2, 1'b1);
    end
    req = 8'h00;
    step();
    check_all("final_idle", 8'h00, 3'd2, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
